serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor. Computes diff = A - B - bin over WIDTH bits, STEP bits per clock, by rippling a registered borrow through STEP full-subtractor cells.
- Successor to the single-bit combinational full subtractor. Adds width, throughput/area trade-off, a start/done handshake, and a signed-overflow flag.
- Used wherever a narrow datapath must subtract wide operands.

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- STEP, 1, bits processed per clock; STEP >= 1; WIDTH % STEP == 0 (elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when idle.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  initial borrow-in; captured on accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  difference, two's-complement wrap.
- bout  output  1  final borrow-out (unsigned a < b + bin).
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (rst_n low at an edge) forces state IDLE and busy=0, done=0, diff=0, bout=0, ovf=0. Internal operand, borrow and count registers also clear. Reset aborts any operation in progress with no done pulse.
- States and transitions:
  - IDLE: start=1 → RUN, with a, b, bin captured and the chunk counter set to 0.
  - RUN: each edge processes chunk k (bits k*STEP .. k*STEP+STEP-1, LSB first). The STEP cells chain the borrow; the chunk's borrow-out is registered for the next chunk. After chunk N-1 (N = WIDTH/STEP) → DONE.
  - DONE: single cycle. done=1; diff/bout/ovf are updated on the edge entering DONE. Next edge → RUN if start=1, else IDLE.
- Latency: start accepted at edge t0. Chunks are processed at edges t0+1 .. t0+N. done is high in the cycle after edge t0+N.
- busy=1 from edge t0 until edge t0+N. busy=0 in DONE and IDLE.
- Inputs: start while busy=1 is ignored. a, b and bin changes after capture have no effect.
- Back-to-back: start high during the DONE cycle is accepted, giving no idle gap.
- Outputs diff/bout/ovf hold their last result until the next DONE or a reset. They do not change during RUN.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout is the borrow out of the MSB cell. ovf is computed from captured a/b and final diff.
- With STEP=WIDTH: N=1, done is high 2 cycles after start is sampled.

Decomposition:
- Package serial_subtractor_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - a function computing count width, $clog2(WIDTH/STEP) with a minimum of 1.
- Sub-module full_subtractor: the combinational 1-bit cell with ports A, B, Bin, Diff, Bout. Instantiated STEP times in a generate loop.
- Counter, state register and operand shift registers live in the top.

Test Plan:
1. WIDTH=8, STEP=1: a=0x05, b=0x03, bin=0, start pulse → busy high 8 cycles, then done; diff=0x02, bout=0, ovf=0.
2. WIDTH=8, STEP=1: a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
3. WIDTH=8, STEP=1: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
4. Start re-asserted mid-RUN with different operands → ignored; first result delivered unchanged. Start held in DONE cycle → second op begins immediately; its done follows 8 cycles later.
5. rst_n low at edge t0+4 of an op → busy=0, done never pulses, diff/bout/ovf=0. A new start after release completes normally.
6. WIDTH=8, STEP=4 (N=2) and STEP=8 (N=1): all 8 single-bit-cell corner combos on LSBs, plus 256 random pairs with random bin, checked against a - b - bin. Latency checked as N+1 cycles from start edge to done.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor.
//   state_e   : controller state (IDLE, RUN, DONE), also exported on the
//               debug port of the top.
//   cnt_width : width of the chunk counter for a given chunk count,
//               never less than one bit.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n_chunks);
    if (n_chunks <= 1) begin
      return 1;
    end
    return $clog2(n_chunks);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational single-bit full subtractor cell: A - B - Bin.
// Ports:
//   A, B  : operand bits
//   Bin   : borrow in
//   Diff  : difference bit
//   Bout  : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  // Borrow when B alone exceeds A, or when A == B and a borrow arrives.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, STEP bits
// per clock, LSB chunk first, with the borrow registered between chunks.
//
// Ports:
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   start             : request, only honoured in IDLE or DONE
//   a, b, bin         : operands, captured when start is honoured
//   busy              : high from the accepting edge until the last chunk
//   done              : one-cycle pulse, diff/bout/ovf valid
//   diff, bout, ovf   : result, held until the next DONE or reset
//   dbg_state         : current controller state
//
// Handshake: start is a level request sampled on each rising edge while
// the block is idle (IDLE or DONE). A sampled start captures a/b/bin and
// raises busy; start seen while busy is dropped. Exactly N = WIDTH/STEP
// edges later done pulses for one cycle with the result on diff/bout/ovf.
// Holding start through the DONE cycle chains the next operation with no
// idle cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output state_e           dbg_state
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("serial_subtractor: WIDTH must be >= 2 and a multiple of STEP");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             borrow_q;
  logic             a_msb_q, b_msb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, bout_q, ovf_q;
  logic [WIDTH-1:0] diff_q;

  // Borrow chain through the STEP cells of the current chunk.
  logic [STEP:0]    brw;
  logic [STEP-1:0]  chunk_diff;

  assign brw[0] = borrow_q;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_cell
    full_subtractor u_fs (
      .A    (a_q[gi]),
      .B    (b_q[gi]),
      .Bin  (brw[gi]),
      .Diff (chunk_diff[gi]),
      .Bout (brw[gi+1])
    );
  end

  // Operands shift right so the active chunk always sits in the low STEP
  // bits; result bits enter from the top so that after N chunks res holds
  // the full difference in place.
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic             ovf_d;
  logic             accept;

  always_comb begin
    a_d    = a_q >> STEP;
    b_d    = b_q >> STEP;
    res_d  = (res_q >> STEP) | (WIDTH'(chunk_diff) << (WIDTH - STEP));
    // On the last chunk chunk_diff[STEP-1] is the result MSB.
    ovf_d  = (a_msb_q != b_msb_q) && (chunk_diff[STEP-1] != a_msb_q);
    accept = start && (state_q == IDLE || state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q  <= RUN;
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        a_msb_q  <= a[WIDTH-1];
        b_msb_q  <= b[WIDTH-1];
        res_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= brw[STEP];
            if (cnt_q == LAST_CHUNK) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              diff_q  <= res_d;
              bout_q  <= brw[STEP];
              ovf_q   <= ovf_d;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          IDLE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (STEP = 1, 4, 8 at WIDTH 8)
// driven independently, a table of directed vectors, hand-written
// multi-cycle sequences, and random operands against an arithmetic model.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start_v[3];
  logic [W-1:0]   a_v[3], b_v[3];
  logic           bin_v[3];
  logic           busy_v[3], done_v[3], bout_v[3], ovf_v[3];
  logic [W-1:0]   diff_v[3];
  state_e         st_v[3];
  int             steps[3] = '{1, 4, 8};

  serial_subtractor #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .bin(bin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]),
    .bout(bout_v[0]), .ovf(ovf_v[0]), .dbg_state(st_v[0]));

  serial_subtractor #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .bin(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]),
    .bout(bout_v[1]), .ovf(ovf_v[1]), .dbg_state(st_v[1]));

  serial_subtractor #(.WIDTH(W), .STEP(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .bin(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]),
    .bout(bout_v[2]), .ovf(ovf_v[2]), .dbg_state(st_v[2]));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];   // {ovf, bout, diff}

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Plain integer arithmetic: unsigned difference for diff/bout, signed
  // difference range test for ovf.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int d, sd;
    logic [W-1:0] dv;
    logic ov, bo;
    d  = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    dv = W'(d + (1 << W));
    bo = (d < 0);
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {ov, bo, dv};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one start pulse; returns just after the accepting edge.
  task automatic start_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W+1:0] e);
    exp_q.push_back(e);
    a_v[k]     = a;
    b_v[k]     = b;
    bin_v[k]   = bin;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_v[k]     = W'($urandom);
    b_v[k]     = W'($urandom);
    bin_v[k]   = 1'($urandom_range(0, 1));
  endtask

  // cyc0 = edges seen so far, counting the accepting edge as 1.
  task automatic finish_op(input int k, input string name, input int cyc0,
                           output logic [W+1:0] e);
    int cyc;
    string nm;
    cyc = cyc0;
    nm  = $sformatf("%s_s%0d", name, steps[k]);
    while (!done_v[k] && cyc < 40) begin
      chk({nm, "_busy_run"}, 32'(busy_v[k]), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_done_seen"}, 32'(done_v[k]), 32'd1);
    chk({nm, "_latency"}, 32'(cyc), 32'(W / steps[k] + 1));
    chk({nm, "_busy_done"}, 32'(busy_v[k]), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({nm, "_diff"}, 32'(diff_v[k]), 32'(e[W-1:0]));
    chk({nm, "_bout"}, 32'(bout_v[k]), 32'(e[W]));
    chk({nm, "_ovf"},  32'(ovf_v[k]),  32'(e[W+1]));
  endtask

  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W+1:0] exp_res, input string name);
    logic [W+1:0] e;
    start_op(k, a, b, bin, exp_res);
    finish_op(k, name, 1, e);
    @(posedge clk); #1;
    chk($sformatf("%s_s%0d_pulse", name, steps[k]), 32'(done_v[k]), 32'd0);
    chk($sformatf("%s_s%0d_hold", name, steps[k]),
        32'({ovf_v[k], bout_v[k], diff_v[k]}), 32'(e));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic         seen_done;

    tbl[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[5]  = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
    tbl[10] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
      bin_v[k]   = 1'b0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_s%0d", steps[k]), 32'(busy_v[k]), 32'd0);
      chk($sformatf("rst_done_s%0d", steps[k]), 32'(done_v[k]), 32'd0);
      chk($sformatf("rst_diff_s%0d", steps[k]), 32'(diff_v[k]), 32'd0);
      chk($sformatf("rst_bout_s%0d", steps[k]), 32'(bout_v[k]), 32'd0);
      chk($sformatf("rst_ovf_s%0d",  steps[k]), 32'(ovf_v[k]),  32'd0);
      chk($sformatf("rst_state_s%0d", steps[k]), 32'(st_v[k]), 32'(IDLE));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on every step size
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 14; i++) begin
        run_op(k, tbl[i].a, tbl[i].b, tbl[i].bin,
               {tbl[i].ovf, tbl[i].bout, tbl[i].diff}, $sformatf("tbl%0d", i));
      end
    end

    // Start re-asserted mid-run with other operands must be ignored
    start_op(0, 8'h05, 8'h03, 1'b0, model(8'h05, 8'h03, 1'b0));
    repeat (2) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    a_v[0]     = 8'hFF;
    b_v[0]     = 8'h00;
    bin_v[0]   = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    finish_op(0, "midstart", 4, e);
    @(posedge clk); #1;
    chk("midstart_no_second_op", 32'(busy_v[0]), 32'd0);

    // Back-to-back: start held through the DONE cycle
    start_op(0, 8'h10, 8'h01, 1'b0, model(8'h10, 8'h01, 1'b0));
    finish_op(0, "b2b_first", 1, e);
    exp_q.push_back(model(8'h20, 8'h02, 1'b1));
    start_v[0] = 1'b1;
    a_v[0]     = 8'h20;
    b_v[0]     = 8'h02;
    bin_v[0]   = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("b2b_no_gap_busy", 32'(busy_v[0]), 32'd1);
    finish_op(0, "b2b_second", 1, e);
    @(posedge clk); #1;

    // Reset mid-operation: leaves nonzero outputs first, then aborts
    run_op(0, 8'h7F, 8'hFF, 1'b0, model(8'h7F, 8'hFF, 1'b0), "pre_rst");
    start_op(0, 8'h44, 8'h11, 1'b0, model(8'h44, 8'h11, 1'b0));
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_diff", 32'(diff_v[0]), 32'd0);
    chk("abort_bout", 32'(bout_v[0]), 32'd0);
    chk("abort_ovf",  32'(ovf_v[0]),  32'd0);
    chk("abort_state", 32'(st_v[0]), 32'(IDLE));
    void'(exp_q.pop_back());
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0]) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    run_op(0, 8'h44, 8'h11, 1'b0, model(8'h44, 8'h11, 1'b0), "post_rst");

    // Random operands against the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ((k == 0) ? 64 : 256); i++) begin
        ra   = W'($urandom);
        rb   = W'($urandom);
        rbin = 1'($urandom_range(0, 1));
        run_op(k, ra, rb, rbin, model(ra, rb, rbin), "rnd");
      end
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
